// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Also holds the sign-fixup that turns the raw accumulator into the final result.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  localparam int          MDU_STEPS = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  // acc holds {hi, lo} of the magnitude product, or {remainder, quotient}.
  function automatic logic [31:0] mdu_finish(input mdu_op_e op, input logic neg,
                                             input logic [63:0] acc);
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;
    prod = neg ? -acc : acc;
    quot = neg ? -acc[31:0] : acc[31:0];
    rem  = neg ? -acc[63:32] : acc[63:32];
    case (op)
      OP_MUL:                        return prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  return prod[63:32];
      OP_DIV, OP_DIVU:               return quot;
      default:                       return rem;
    endcase
  endfunction

endpackage

// File: rtl/mdu_iterative.sv
// Iterative radix-2 RV32M multiply/divide unit with a 33-cycle normal latency
// and a single-cycle fast path for divide-by-zero and signed overflow.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mdu_state_e        state_q, state_d;
  mdu_op_e           op_q, op_d, op_in;
  logic [4:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              sign1, sign2, div0, ovf, accept, last_step;
  logic [XLEN-1:0]   mag1, mag2, fast_val;
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] step_acc;

  always_comb begin : decode
    op_in = mdu_op_e'(op);
    sign1 = op1[XLEN-1] & (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    sign2 = op2[XLEN-1] & (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
    mag1  = sign1 ? -op1 : op1;
    mag2  = sign2 ? -op2 : op2;
    div0  = op[2] & (op2 == '0);
    ovf   = ((op_in == OP_DIV) | (op_in == OP_REM)) & (op1 == INT_MIN) & (op2 == '1);
    if (div0) begin
      fast_val = ((op_in == OP_DIV) | (op_in == OP_DIVU)) ? DIV0_QUOT : op1;
    end else begin
      fast_val = (op_in == OP_DIV) ? INT_MIN : '0;
    end
  end

  // Multiply consumes the multiplier from acc[0] and shifts right; divide
  // shifts left, trial-subtracting the divisor from the partial remainder.
  always_comb begin : step
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    if (op_q[2]) begin
      step_acc = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                 : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      step_acc = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  assign accept    = start & ~flush & (state_q != CALC);
  assign last_step = (cnt_q == 5'(MDU_STEPS - 1));

  always_comb begin : fsm
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    result_d = result_q;
    if (state_q == CALC) begin
      if (flush) begin
        state_d = IDLE;
      end else begin
        acc_d = step_acc;
        cnt_d = cnt_q + 5'd1;
        if (last_step) begin
          state_d  = DONE;
          result_d = mdu_finish(op_q, neg_q, step_acc);
        end
      end
    end else if (accept) begin
      op_d  = op_in;
      cnt_d = '0;
      neg_d = ((op_in == OP_REM) | (op_in == OP_REMU)) ? sign1 : (sign1 ^ sign2);
      if (div0 | ovf) begin
        state_d  = DONE;
        result_d = fast_val;
      end else begin
        state_d = CALC;
        acc_d   = {{XLEN{1'b0}}, mag1};
        opnd_d  = mag2;
      end
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: doc/mdu_iterative.md
# mdu_iterative

Iterative RV32M multiply/divide unit for the execute stage. It sits beside the combinational ALU and feeds the same execute-result mux. It accepts one operation per start pulse, computes it over multiple cycles with a radix-2 shift-add or shift-subtract datapath, and presents a held result with a one-cycle done pulse. The hazard unit stalls the pipeline on `busy`.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request. Sampled only when `busy`=0.
- `flush`, input, 1: abort the in-flight operation; takes priority over `start`.
- `op`, input, 3: funct3 encoding. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `op1`, input, 32: rs1 operand (multiplicand or dividend).
- `op2`, input, 32: rs2 operand (multiplier or divisor).
- `busy`, output, 1: high while an operation is computing.
- `done`, output, 1: one-cycle pulse; `result` is valid in this cycle.
- `result`, output, 32: final value; held until the next accepted start.

## Operation
- States: IDLE, CALC, DONE.
  - IDLE/DONE + `start` (no `flush`) → CALC, or → DONE directly on the fast path.
  - CALC counts 32 steps, then → DONE.
  - DONE → IDLE unless a new `start` is accepted.
- On accept, register `op`, the operand magnitudes and the sign flags.
  - Signed ops (MULH, DIV, REM, MUL): `op1` and `op2` are signed.
  - MULHSU: `op1` signed, `op2` unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - MUL: the low word is sign-independent.
- Multiply: 64-bit unsigned shift-add on magnitudes, one multiplier bit per cycle. Negate the product if the operand signs differ.
  - MUL returns `[31:0]`.
  - MULH, MULHSU and MULHU return `[63:32]`.
- Divide: restoring division on magnitudes, one quotient bit per cycle. The quotient sign is sign1 XOR sign2; the remainder takes the dividend sign.
- Fast path, no CALC (result available in the DONE cycle):
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give `op1`.
  - Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: gives 0x80000000; REM gives 0.
- `start` while `busy`=1 is ignored and does not queue.
- `flush`: next state IDLE from any state. No `done` pulse; `result` keeps its previous value.
- Reset: state IDLE, `busy`=0, `done`=0, `result`=0, counter 0, all datapath registers 0.

## Timing
- Accept at edge E0.
  - Normal path: `busy`=1 after E0 through edge E32 (32 CALC cycles). `done`=1 and `result` valid in the cycle after E32, i.e. latency 33 cycles.
  - Fast path: `busy` stays 0, and `done` is asserted in the cycle after E0 (latency 1).
- `busy` is 0 in DONE, so a new `start` is accepted in the same cycle as `done` (back-to-back). `done` and `result` update from that new op at its completion.
- `result` is registered and `done` is a registered, glitch-free pulse.
- Operand inputs may change after the accept edge without effect.
- `flush` and `start` in the same cycle: `flush` wins and the start is dropped.
- `flush` in the same cycle as the final CALC step: no `done`, and `result` is not updated.
- Asynchronous reset mid-CALC: immediate return to IDLE; `busy` falls without waiting for a clock.

## Structure
- `mdu_pkg` holds:
  - the `mdu_op_e` enum for funct3 values 0–7;
  - the state enum `{IDLE, CALC, DONE}`;
  - the constants `MDU_STEPS`=32, `DIV0_QUOT`=32'hFFFF_FFFF and `INT_MIN`=32'h8000_0000.
- Single module with one shared step counter. A separate sub-module is not warranted; the multiply and divide datapaths share the 64-bit accumulator register.

## Test plan
- MUL 7 × −3 (0xFFFFFFFD) → `result` 0xFFFFFFEB, `done` 33 cycles after accept, `busy` high for exactly 32 cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD. REM −7 / 2 → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIV 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5, each with `done` 1 cycle after accept and `busy` never high. DIV 0x80000000 / −1 → 0x80000000 with REM 0.
- Back-to-back: start a second op in the `done` cycle → accepted, second `done` 33 cycles later. `start` pulses during `busy` are ignored, with no extra `done`.
- `flush` at CALC step 10 → IDLE next cycle, no `done`, `result` unchanged. Assert `reset_n`=0 mid-CALC → `busy`, `done` and `result` go to 0 asynchronously.
